// File: rtl/sbp_pkg.sv
// sbp_pkg: shared field widths, head-slot bus and update FIFO entry types
package sbp_pkg;
  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int RESULT_BITS   = 24;
  localparam logic [STAGE_ID_BITS-1:0] BUBBLE_STAGE_ID = '0;

  typedef enum logic {IDLE, BATCH} state_t;

  typedef struct packed {
    logic                     update;
    logic [31:0]              ip_addr;
    logic [5:0]               bit_pos;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } head_t;

  typedef struct packed {
    logic                     last;
    logic [31:0]              prefix;
    logic [5:0]               length;
    logic [STAGE_ID_BITS-1:0] stage_id;
    logic [LOCATION_BITS-1:0] location;
    logic [RESULT_BITS-1:0]   result;
  } upd_entry_t;

  function automatic logic [5:0] sat_len(input logic [5:0] l);
    return l > 6'd32 ? 6'd32 : l;
  endfunction
endpackage

// File: rtl/sbp_pipeline_injector_if.sv
// sbp_pipeline_injector_if: lookup, update and pipeline-head signals of the injector
interface sbp_pipeline_injector_if
  import sbp_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic                     lkp_valid_i;
  logic                     lkp_ready_o;
  logic [31:0]              lkp_ip_addr_i;
  logic                     upd_valid_i;
  logic                     upd_ready_o;
  logic                     upd_last_i;
  logic [31:0]              upd_prefix_i;
  logic [5:0]               upd_length_i;
  logic [STAGE_ID_BITS-1:0] upd_stage_id_i;
  logic [LOCATION_BITS-1:0] upd_location_i;
  logic [RESULT_BITS-1:0]   upd_result_i;
  logic                     update_o;
  logic [31:0]              ip_addr_o;
  logic [5:0]               bit_pos_o;
  logic [STAGE_ID_BITS-1:0] stage_id_o;
  logic [LOCATION_BITS-1:0] location_o;
  logic [RESULT_BITS-1:0]   result_o;
  logic                     batch_busy_o;
  logic [LW-1:0]            fifo_level_o;
  logic                     err_o;

  modport master (
    output lkp_valid_i, lkp_ip_addr_i, upd_valid_i, upd_last_i, upd_prefix_i,
           upd_length_i, upd_stage_id_i, upd_location_i, upd_result_i,
    input  lkp_ready_o, upd_ready_o, update_o, ip_addr_o, bit_pos_o, stage_id_o,
           location_o, result_o, batch_busy_o, fifo_level_o, err_o
  );
  modport slave (
    input  lkp_valid_i, lkp_ip_addr_i, upd_valid_i, upd_last_i, upd_prefix_i,
           upd_length_i, upd_stage_id_i, upd_location_i, upd_result_i,
    output lkp_ready_o, upd_ready_o, update_o, ip_addr_o, bit_pos_o, stage_id_o,
           location_o, result_o, batch_busy_o, fifo_level_o, err_o
  );
endinterface

// File: rtl/sbp_sync_fifo.sv
// sbp_sync_fifo: single-clock FIFO with first-word-fall-through read and level output
module sbp_sync_fifo #(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  logic [W-1:0]         i_din,
  input  logic                 i_pop,
  output logic [W-1:0]         o_dout,
  output logic                 o_full,
  output logic [$clog2(D):0]   o_level
);
  localparam int AW = $clog2(D);
  logic [W-1:0]  r_mem [D];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      r_wr    <= r_wr + AW'(i_push);
      r_rd    <= r_rd + AW'(i_pop);
      r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_full  = r_level == (AW+1)'(D);
  assign o_level = r_level;
endmodule

// File: rtl/sbp_pipeline_injector.sv
// sbp_pipeline_injector: merges lookups and batched table updates into the pipeline head slot
module sbp_pipeline_injector
  import sbp_pkg::*;
#(
  parameter int FIFO_DEPTH    = 16,
  parameter int ROOT_STAGE_ID = 1
) (
  input logic clk,
  input logic rst,
  sbp_pipeline_injector_if.slave bus
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  state_t        r_state, w_state;
  logic          r_turn, w_turn, r_err, w_full, w_push, w_pop, w_lkp_acc, w_ovf;
  logic [LW-1:0] r_batch_cnt, w_level;
  head_t         r_head, w_head;
  upd_entry_t    w_din, w_dout;

  assign w_push          = bus.upd_valid_i && !w_full;
  assign w_ovf           = w_full && r_batch_cnt == '0;
  assign w_lkp_acc       = bus.lkp_valid_i && bus.lkp_ready_o;
  assign bus.upd_ready_o = !w_full;
  assign bus.lkp_ready_o = r_state == IDLE && (r_batch_cnt == '0 || r_turn);
  assign w_din = '{last: bus.upd_last_i, prefix: bus.upd_prefix_i,
                   length: sat_len(bus.upd_length_i), stage_id: bus.upd_stage_id_i,
                   location: bus.upd_location_i, result: bus.upd_result_i};

  sbp_sync_fifo #(.W($bits(upd_entry_t)), .D(FIFO_DEPTH)) u_fifo (
    .clk, .rst, .i_push(w_push), .i_din(w_din), .i_pop(w_pop),
    .o_dout(w_dout), .o_full(w_full), .o_level(w_level)
  );

  // An overflowed FIFO holds no last word, so a drain also ends when the FIFO runs dry
  always_comb begin
    w_state = r_state;
    w_turn  = r_turn;
    w_pop   = 1'b0;
    w_head  = '{default: '0, stage_id: BUBBLE_STAGE_ID};
    if (r_state == BATCH) begin
      w_pop = 1'b1;
      if (w_dout.last || (w_level == LW'(1) && !w_push)) begin
        w_state = IDLE;
        w_turn  = 1'b1;
      end
    end else if (w_lkp_acc) begin
      w_head = '{default: '0, ip_addr: bus.lkp_ip_addr_i,
                 stage_id: STAGE_ID_BITS'(ROOT_STAGE_ID)};
      w_turn = 1'b0;
    end else if (r_batch_cnt != '0 || w_ovf) begin
      w_pop   = 1'b1;
      w_state = w_dout.last ? IDLE : BATCH;
      w_turn  = w_dout.last;
    end
    if (w_pop)
      w_head = '{update: 1'b1, ip_addr: w_dout.prefix, bit_pos: w_dout.length,
                 stage_id: w_dout.stage_id, location: w_dout.location,
                 result: w_dout.result};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_turn      <= 1'b0;
      r_err       <= 1'b0;
      r_batch_cnt <= '0;
      r_head      <= '0;
    end else begin
      r_state     <= w_state;
      r_turn      <= w_turn;
      r_err       <= r_err | w_ovf;
      r_batch_cnt <= r_batch_cnt + LW'(w_push && bus.upd_last_i) - LW'(w_pop && w_dout.last);
      r_head      <= w_head;
    end
  end

  assign bus.update_o     = r_head.update;
  assign bus.ip_addr_o    = r_head.ip_addr;
  assign bus.bit_pos_o    = r_head.bit_pos;
  assign bus.stage_id_o   = r_head.stage_id;
  assign bus.location_o   = r_head.location;
  assign bus.result_o     = r_head.result;
  assign bus.batch_busy_o = r_head.update;
  assign bus.fifo_level_o = w_level;
  assign bus.err_o        = r_err;
endmodule

// File: tb/tb_sbp_pipeline_injector.sv
// tb_sbp_pipeline_injector: directed and random checks against a queue-based reference model
module tb_sbp_pipeline_injector;
  import sbp_pkg::*;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sbp_pipeline_injector_if #(.FIFO_DEPTH(D)) bus();
  sbp_pipeline_injector #(.FIFO_DEPTH(D), .ROOT_STAGE_ID(1)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic head_t cur();
    return '{update: bus.update_o, ip_addr: bus.ip_addr_o, bit_pos: bus.bit_pos_o,
             stage_id: bus.stage_id_o, location: bus.location_o, result: bus.result_o};
  endfunction

  function automatic head_t word(input upd_entry_t e);
    return '{update: 1'b1, ip_addr: e.prefix, bit_pos: e.length, stage_id: e.stage_id,
             location: e.location, result: e.result};
  endfunction

  // reference model: buffered words as a queue, batch readiness counted from the queue
  upd_entry_t mq[$];
  upd_entry_t me;
  head_t      m_head, nh;
  bit         m_batch, m_turn, m_err, known, m_full, m_push, m_acc;
  bit         m_ur, m_lr;
  int         nb;

  function automatic int n_last();
    int n = 0;
    foreach (mq[i]) n += int'(mq[i].last);
    return n;
  endfunction

  always @(negedge clk) begin
    if (known) begin
      chk("head", cur(), m_head);
      chk("busy", bus.batch_busy_o, m_head.update);
      chk("level", bus.fifo_level_o, mq.size());
      chk("err", bus.err_o, m_err);
    end
    if (rst) begin
      mq.delete();
      m_batch = 0; m_turn = 0; m_err = 0; known = 1;
      m_head = '0;
    end else if (known) begin
      m_full = mq.size() == D;
      nb     = n_last();
      m_ur   = !m_full;
      m_lr   = !m_batch && (nb == 0 || m_turn);
      chk("upd_ready", bus.upd_ready_o, m_ur);
      chk("lkp_ready", bus.lkp_ready_o, m_lr);
      m_push = bus.upd_valid_i && m_ur;
      m_acc  = bus.lkp_valid_i && m_lr;
      nh = '0;
      if (m_batch) begin
        if (mq.size() > 0) begin
          me = mq.pop_front();
          nh = word(me);
          if (me.last || (mq.size() == 0 && !m_push)) begin
            m_batch = 0; m_turn = 1;
          end
        end
      end else if (m_acc) begin
        nh = '{default: '0, ip_addr: bus.lkp_ip_addr_i, stage_id: 6'd1};
        m_turn = 0;
      end else if (nb > 0 || m_full) begin
        me = mq.pop_front();
        nh = word(me);
        if (me.last) m_turn = 1; else m_batch = 1;
      end
      if (m_full && nb == 0) m_err = 1;
      if (m_push)
        mq.push_back('{last: bus.upd_last_i, prefix: bus.upd_prefix_i,
                       length: bus.upd_length_i > 6'd32 ? 6'd32 : bus.upd_length_i,
                       stage_id: bus.upd_stage_id_i, location: bus.upd_location_i,
                       result: bus.upd_result_i});
      m_head = nh;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input bit last, input logic [31:0] p, input logic [5:0] l,
                           input logic [5:0] s, input logic [10:0] loc, input logic [23:0] r);
    bus.upd_valid_i = 1'b1; bus.upd_last_i = last; bus.upd_prefix_i = p;
    bus.upd_length_i = l; bus.upd_stage_id_i = s; bus.upd_location_i = loc;
    bus.upd_result_i = r;
  endtask

  head_t log_h[24];
  int    idx, run;

  task automatic collect(input int n, input bit lkp);
    for (int i = 0; i < n; i++) begin
      log_h[i] = cur();
      bus.lkp_ip_addr_i = $urandom;
      bus.lkp_valid_i = lkp;
      step();
    end
  endtask

  task automatic find_upd(input int n);
    idx = -1;
    for (int i = n - 1; i >= 0; i--) if (log_h[i].update) idx = i;
  endtask

  initial begin
    bus.lkp_valid_i = 0; bus.lkp_ip_addr_i = 0; bus.upd_valid_i = 0; bus.upd_last_i = 0;
    bus.upd_prefix_i = 0; bus.upd_length_i = 0; bus.upd_stage_id_i = 0;
    bus.upd_location_i = 0; bus.upd_result_i = 0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_lkp_ready", bus.lkp_ready_o, 1'b1);
    chk("rst_upd_ready", bus.upd_ready_o, 1'b1);
    chk("rst_head", cur(), 80'h0);
    chk("rst_level", bus.fifo_level_o, 5'd0);
    chk("rst_err", bus.err_o, 1'b0);

    // idle lookups
    bus.lkp_valid_i = 1; bus.lkp_ip_addr_i = 32'h0A000001;
    step();
    bus.lkp_ip_addr_i = 32'h0A000002;
    chk("lkp1", cur(), {1'b0, 32'h0A000001, 6'd0, 6'd1, 11'd0, 24'd0});
    step();
    bus.lkp_valid_i = 0;
    chk("lkp2", cur(), {1'b0, 32'h0A000002, 6'd0, 6'd1, 11'd0, 24'd0});
    step();
    chk("bubble_stage", bus.stage_id_o, 6'd0);

    // three-word batch under continuous lookups
    bus.lkp_valid_i = 1;
    drive_upd(0, 32'h0A000000, 6'd8, 6'd1, 11'd0, 24'h111111); step();
    drive_upd(0, 32'h0A800000, 6'd9, 6'd2, 11'd4, 24'h222222); step();
    drive_upd(1, 32'h0AC00000, 6'd10, 6'd3, 11'd7, 24'h333333); step();
    bus.upd_valid_i = 0;
    collect(12, 1);
    find_upd(12);
    chk("batch3_found", idx >= 0 && idx <= 7, 1'b1);
    if (idx >= 0 && idx <= 7) begin
      chk("batch3_w0", log_h[idx],   {1'b1, 32'h0A000000, 6'd8, 6'd1, 11'd0, 24'h111111});
      chk("batch3_w1", log_h[idx+1], {1'b1, 32'h0A800000, 6'd9, 6'd2, 11'd4, 24'h222222});
      chk("batch3_w2", log_h[idx+2], {1'b1, 32'h0AC00000, 6'd10, 6'd3, 11'd7, 24'h333333});
      chk("batch3_lkp", {log_h[idx+3].update, log_h[idx+3].stage_id}, {1'b0, 6'd1});
    end

    // two queued single-word batches with lookups pending
    drive_upd(1, 32'h0B000000, 6'd40, 6'd4, 11'd5, 24'hAAAAAA); step();
    drive_upd(1, 32'h0C000000, 6'd16, 6'd5, 11'd6, 24'hBBBBBB); step();
    bus.upd_valid_i = 0;
    collect(10, 1);
    find_upd(10);
    chk("pair_found", idx >= 0 && idx <= 6, 1'b1);
    if (idx >= 0 && idx <= 6) begin
      chk("pair_a", log_h[idx], {1'b1, 32'h0B000000, 6'd32, 6'd4, 11'd5, 24'hAAAAAA});
      chk("pair_lkp1", {log_h[idx+1].update, log_h[idx+1].stage_id}, {1'b0, 6'd1});
      chk("pair_b", log_h[idx+2], {1'b1, 32'h0C000000, 6'd16, 6'd5, 11'd6, 24'hBBBBBB});
      chk("pair_lkp2", {log_h[idx+3].update, log_h[idx+3].stage_id}, {1'b0, 6'd1});
    end

    // overflow: a batch longer than the FIFO
    bus.lkp_valid_i = 0;
    repeat (3) step();
    for (int i = 0; i < D; i++) begin
      drive_upd(0, 32'(i) << 24, 6'($urandom_range(0, 32)), 6'd2, 11'(i), 24'(i));
      step();
    end
    drive_upd(0, 32'hFF000000, 6'd1, 6'd2, 11'd0, 24'd0);
    chk("ovf_ready_low", bus.upd_ready_o, 1'b0);
    chk("ovf_level", bus.fifo_level_o, 5'd16);
    step();
    bus.upd_valid_i = 0;
    chk("ovf_err", bus.err_o, 1'b1);
    collect(20, 0);
    run = 0;
    while (run < 20 && log_h[run].update) run++;
    chk("ovf_run", run, 16);
    chk("ovf_first", log_h[0].ip_addr, 32'h00000000);
    chk("ovf_last", log_h[15].ip_addr, 32'h0F000000);
    chk("ovf_err_sticky", bus.err_o, 1'b1);

    // reset during the second word of a three-word batch
    drive_upd(0, 32'h11000000, 6'd8, 6'd1, 11'd1, 24'h1); step();
    drive_upd(0, 32'h22000000, 6'd8, 6'd2, 11'd2, 24'h2); step();
    drive_upd(1, 32'h33000000, 6'd8, 6'd3, 11'd3, 24'h3); step();
    bus.upd_valid_i = 0;
    step();
    step();
    chk("mid_w1", cur(), {1'b1, 32'h22000000, 6'd8, 6'd2, 11'd2, 24'h2});
    rst = 1'b1;
    step();
    chk("mid_bubble", cur(), 80'h0);
    chk("mid_level", bus.fifo_level_o, 5'd0);
    chk("mid_busy", bus.batch_busy_o, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_upd", bus.update_o, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.lkp_valid_i = ($urandom % 3) != 0;
      bus.lkp_ip_addr_i = $urandom;
      bus.upd_valid_i = $urandom % 2;
      bus.upd_last_i = ($urandom % 4) == 0;
      bus.upd_prefix_i = $urandom;
      bus.upd_length_i = 6'($urandom % 64);
      bus.upd_stage_id_i = 6'($urandom);
      bus.upd_location_i = 11'($urandom);
      bus.upd_result_i = 24'($urandom);
      rst = ($urandom % 600) == 0;
      step();
    end
    rst = 1'b0;
    bus.lkp_valid_i = 0;
    bus.upd_valid_i = 0;
    repeat (40) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
